fx3_packet_streamer: RTL and testbench

- Sits directly downstream of the data generator, in the fx3Clk domain.
- Waits until a full packet of samples is buffered (dataAvailable) and the FX3 has a free DMA buffer (fx3Ready).
- Then burst-reads exactly PACKET_WORDS 16-bit words from the sample FIFO and drives them onto the FX3 GPIF bus, with write strobe and end-of-packet marker.
- Also keeps a sticky overflow flag and a packet counter for status reporting.

---
 rtl/fx3_pkg.sv | 22 ++
 rtl/fx3_valid_pipe.sv | 52 +++++
 rtl/fx3_packet_streamer.sv | 117 +++++++++++
 tb/tb_fx3_packet_streamer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx3_pkg.sv
// fx3_pkg: shared definitions for the FX3 packet streamer.
//   state_t          - streamer FSM encoding
//   DEF_PACKET_WORDS - default USB packet length in 16-bit words
//   DEF_CNT_W        - word-counter width for the default packet length
//   cnt_width()      - word-counter width for any packet length
package fx3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam int DEF_PACKET_WORDS = 8192;
  localparam int DEF_CNT_W        = $clog2(DEF_PACKET_WORDS);

  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/fx3_valid_pipe.sv
// fx3_valid_pipe: READ_LATENCY-deep shift register that tracks which cycles
// of the FIFO read path carry a real word, plus a tag marking the last word
// of the packet. At the pipeline tail the word is registered onto the bus.
//   fx3Clk, nReset - clock, async active-low reset
//   rd, rd_last    - read request this cycle / it is the packet's last word
//   din            - word from the FIFO path (aligned to the pipeline tail)
//   wr, pkt_end    - registered write strobe / end-of-packet qualifier
//   dout           - registered bus data, held while wr is low
//   empty          - no read is in flight
//   tail_last      - last word is at the tail this cycle (pre-register)
module fx3_valid_pipe #(
  parameter int READ_LATENCY = 2
) (
  input  logic        fx3Clk,
  input  logic        nReset,
  input  logic        rd,
  input  logic        rd_last,
  input  logic [15:0] din,
  output logic        wr,
  output logic        pkt_end,
  output logic [15:0] dout,
  output logic        empty,
  output logic        tail_last
);

  logic [READ_LATENCY:1] vld_pipe;
  logic [READ_LATENCY:1] tag_pipe;

  always_ff @(posedge fx3Clk or negedge nReset) begin
    if (!nReset) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      wr       <= 1'b0;
      pkt_end  <= 1'b0;
      dout     <= '0;
    end else begin
      vld_pipe[1] <= rd;
      tag_pipe[1] <= rd_last;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      wr      <= vld_pipe[READ_LATENCY];
      pkt_end <= tail_last;
      if (vld_pipe[READ_LATENCY]) dout <= din;
    end
  end

  assign empty     = ~|vld_pipe;
  assign tail_last = vld_pipe[READ_LATENCY] & tag_pipe[READ_LATENCY];

endmodule

// File: rtl/fx3_packet_streamer.sv
// fx3_packet_streamer: bursts one full packet from the sample FIFO onto the
// FX3 GPIF bus once a packet is buffered and the FX3 has a free DMA buffer.
//   fx3Clk, nReset          - GPIF clock, async active-low reset
//   enable                  - capture session active
//   dataAvailable, fx3Ready - a full packet is buffered / FX3 buffer free
//   bufferError             - FIFO near-full/full
//   dataIn                  - word from the FIFO path, READ_LATENCY after readData
//   readData                - FIFO read request
//   fx3Data, fx3Wr          - GPIF bus data and write strobe
//   fx3PktEnd               - high with the last write of each packet
//   overflow                - sticky bufferError seen while enabled
//   packetCount             - completed packets, wraps at 2^16
//   busy                    - FSM not IDLE
module fx3_packet_streamer
  import fx3_pkg::*;
#(
  parameter int PACKET_WORDS = DEF_PACKET_WORDS,
  parameter int READ_LATENCY = 2,
  parameter int GAP_CYCLES   = 4
) (
  input  logic        fx3Clk,
  input  logic        nReset,
  input  logic        enable,
  input  logic        dataAvailable,
  input  logic        bufferError,
  input  logic        fx3Ready,
  input  logic [15:0] dataIn,
  output logic        readData,
  output logic [15:0] fx3Data,
  output logic        fx3Wr,
  output logic        fx3PktEnd,
  output logic        overflow,
  output logic [15:0] packetCount,
  output logic        busy
);

  localparam int            CW        = cnt_width(PACKET_WORDS);
  localparam logic [CW-1:0] LAST_WORD = CW'(PACKET_WORDS - 1);
  localparam logic [3:0]    LAST_GAP  = 4'(GAP_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] word_cnt;
  logic [3:0]    gap_cnt;
  logic          rd_last;
  logic          pipe_empty;
  logic          tail_last;

  // word_cnt is only meaningful while reading, so gate the tag with readData.
  assign rd_last = readData && (word_cnt == LAST_WORD);
  assign busy    = (state != IDLE);

  fx3_valid_pipe #(.READ_LATENCY(READ_LATENCY)) u_pipe (
    .fx3Clk    (fx3Clk),
    .nReset    (nReset),
    .rd        (readData),
    .rd_last   (rd_last),
    .din       (dataIn),
    .wr        (fx3Wr),
    .pkt_end   (fx3PktEnd),
    .dout      (fx3Data),
    .empty     (pipe_empty),
    .tail_last (tail_last)
  );

  always_ff @(posedge fx3Clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      readData <= 1'b0;
      word_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // fx3Ready is only looked at here: a free FX3 buffer always
          // holds a whole packet, so the burst never needs throttling.
          if (enable && dataAvailable && fx3Ready) begin
            state    <= STREAM;
            readData <= 1'b1;
            word_cnt <= '0;
          end
        end
        STREAM: begin
          if (word_cnt == LAST_WORD) begin
            readData <= 1'b0;
            state    <= DRAIN;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end
        DRAIN: begin
          // pkt_end is high during the final write; the pipe is empty by then.
          if (fx3PktEnd && pipe_empty) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == LAST_GAP) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge fx3Clk or negedge nReset) begin
    if (!nReset) begin
      overflow    <= 1'b0;
      packetCount <= '0;
    end else begin
      if (enable && bufferError)       overflow <= 1'b1;
      else if (!enable && state == IDLE) overflow <= 1'b0;
      if (tail_last) packetCount <= packetCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_fx3_packet_streamer.sv
// Scoreboard bench for fx3_packet_streamer. The main instance uses
// PACKET_WORDS=16, READ_LATENCY=2, GAP_CYCLES=4 and a FIFO model that returns
// the in-burst read index; a second free-running instance (PACKET_WORDS=4,
// GAP_CYCLES=1) on a fast clock exercises the packetCount wrap.
module tb_fx3_packet_streamer;
  localparam int PW = 16;
  localparam int RL = 2;
  localparam int GC = 4;

  logic        fx3Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        enable = 1'b0, dataAvailable = 1'b0, bufferError = 1'b0, fx3Ready = 1'b0;
  logic [15:0] dataIn = 16'h0;
  logic        readData, fx3Wr, fx3PktEnd, overflow, busy;
  logic [15:0] fx3Data, packetCount;

  always #5 fx3Clk = ~fx3Clk;

  fx3_packet_streamer #(.PACKET_WORDS(PW), .READ_LATENCY(RL), .GAP_CYCLES(GC)) dut (
    .fx3Clk(fx3Clk), .nReset(nReset), .enable(enable), .dataAvailable(dataAvailable),
    .bufferError(bufferError), .fx3Ready(fx3Ready), .dataIn(dataIn), .readData(readData),
    .fx3Data(fx3Data), .fx3Wr(fx3Wr), .fx3PktEnd(fx3PktEnd), .overflow(overflow),
    .packetCount(packetCount), .busy(busy)
  );

  // wrap instance: inputs held so it streams packets back-to-back
  logic        wclk = 1'b0, wnReset = 1'b0;
  logic        w_en = 1'b1, w_da = 1'b1, w_err = 1'b0, w_rdy = 1'b1;
  logic [15:0] w_din = 16'h1234;
  logic        w_rd, w_wr, w_end, w_ovf, w_busy;
  logic [15:0] w_data, w_count;
  logic        w_done = 1'b0;

  always #1 wclk = ~wclk;

  fx3_packet_streamer #(.PACKET_WORDS(4), .READ_LATENCY(1), .GAP_CYCLES(1)) wdut (
    .fx3Clk(wclk), .nReset(wnReset), .enable(w_en), .dataAvailable(w_da),
    .bufferError(w_err), .fx3Ready(w_rdy), .dataIn(w_din), .readData(w_rd),
    .fx3Data(w_data), .fx3Wr(w_wr), .fx3PktEnd(w_end), .overflow(w_ovf),
    .packetCount(w_count), .busy(w_busy)
  );

  typedef struct packed { logic [15:0] data; logic last; } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int mon_pkts = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {~b, b};
  endfunction

  task automatic push_pkt();
    for (int i = 0; i < PW; i++) exp_q.push_back('{data: word(i), last: (i == PW-1)});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge fx3Clk);
  endtask

  task automatic wait_pkts(input int n, input string name);
    int t;
    t = 0;
    while (mon_pkts < n && t < 200) begin @(negedge fx3Clk); t++; end
    check(name, 32'(mon_pkts >= n), 1);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < 100) begin @(negedge fx3Clk); t++; end
    check(name, busy, 0);
  endtask

  // FIFO path model: word for a read issued in cycle k is on dataIn in cycle k+RL
  initial begin : fifo_model
    logic [15:0] hist [RL];
    int idx;
    idx = 0;
    for (int k = 0; k < RL; k++) hist[k] = 16'h0;
    forever begin
      @(negedge fx3Clk);
      if (!nReset) begin
        idx = 0;
        for (int k = 0; k < RL; k++) hist[k] = 16'h0;
        dataIn = 16'h0;
      end else begin
        dataIn = hist[RL-1];
        for (int k = RL-1; k > 0; k--) hist[k] = hist[k-1];
        if (readData) begin hist[0] = word(idx); idx++; end
        else begin hist[0] = 16'hDEAD; idx = 0; end
      end
    end
  end

  // Scoreboard monitor: pops one expectation per fx3Wr cycle
  initial begin : monitor
    int   rd_run, wr_run, rd_rise;
    logic rd_prev, wr_prev;
    exp_t e;
    rd_run = 0; wr_run = 0; rd_rise = 0; rd_prev = 1'b0; wr_prev = 1'b0;
    forever begin
      @(negedge fx3Clk);
      cyc++;
      if (!nReset) begin
        rd_run = 0; wr_run = 0; rd_prev = 1'b0; wr_prev = 1'b0;
      end else begin
        if (fx3Wr) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_underflow: unexpected write data %0h at %0t", fx3Data, $time);
          end else begin
            e = exp_q.pop_front();
            check("data", fx3Data, e.data);
            check("pkt_end", fx3PktEnd, e.last);
          end
          if (!wr_prev) check("wr_latency", 32'(cyc - rd_rise), RL + 1);
          wr_run++;
        end else begin
          check("pkt_end_idle", fx3PktEnd, 0);
          if (wr_run != 0) check("wr_burst_len", wr_run, PW);
          wr_run = 0;
        end
        if (fx3PktEnd) mon_pkts++;
        if (readData) begin
          if (!rd_prev) rd_rise = cyc;
          rd_run++;
        end else begin
          if (rd_run != 0) check("rd_burst_len", rd_run, PW);
          rd_run = 0;
        end
        rd_prev = readData;
        wr_prev = fx3Wr;
      end
    end
  end

  // Wrap instance checker
  initial begin : wrap_mon
    int n;
    n = 0;
    #5 wnReset = 1'b1;
    forever begin
      @(negedge wclk);
      if (w_end && !w_done) begin
        n++;
        if (n == 1) check("wrap_first", w_count, 16'h0001);
        else if (n == 65535) check("wrap_ffff", w_count, 16'hFFFF);
        else if (n == 65536) begin check("wrap_zero", w_count, 16'h0000); w_done = 1'b1; end
      end
    end
  end

  initial begin : stim
    logic stuck;
    int   pk_before;
    int   t;
    tick(3);
    check("rst_rd", readData, 0);
    check("rst_wr", fx3Wr, 0);
    check("rst_end", fx3PktEnd, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cnt", packetCount, 0);
    check("rst_busy", busy, 0);
    check("rst_data", fx3Data, 0);
    nReset = 1'b1;
    tick(2);

    // basic packet
    push_pkt();
    enable = 1'b1; dataAvailable = 1'b1; fx3Ready = 1'b1;
    tick(1);
    check("t1_busy", busy, 1);
    check("t1_rd", readData, 1);
    dataAvailable = 1'b0; fx3Ready = 1'b0;
    wait_pkts(1, "t1_done");
    check("t1_count", packetCount, 1);
    wait_idle("t1_idle");
    check("t1_rd_idle", readData, 0);

    // held off by fx3Ready
    dataAvailable = 1'b1; stuck = 1'b0;
    repeat (20) begin tick(1); if (busy || readData) stuck = 1'b1; end
    check("t2_held", stuck, 0);
    push_pkt();
    fx3Ready = 1'b1;
    tick(1);
    check("t2_start_busy", busy, 1);
    check("t2_start_rd", readData, 1);
    dataAvailable = 1'b0; fx3Ready = 1'b0;
    wait_pkts(2, "t2_done");
    wait_idle("t2_idle");
    check("t2_count", packetCount, 2);

    // enable drops at word 5: packet completes, nothing follows
    push_pkt();
    dataAvailable = 1'b1; fx3Ready = 1'b1;
    tick(6);
    enable = 1'b0;
    wait_pkts(3, "t3_done");
    wait_idle("t3_idle");
    stuck = 1'b0;
    repeat (30) begin tick(1); if (busy || readData) stuck = 1'b1; end
    check("t3_no_restart", stuck, 0);
    check("t3_count", packetCount, 3);
    dataAvailable = 1'b0; fx3Ready = 1'b0;

    // overflow set/hold/clear
    push_pkt();
    enable = 1'b1; dataAvailable = 1'b1; fx3Ready = 1'b1;
    tick(1);
    dataAvailable = 1'b0; fx3Ready = 1'b0;
    check("t4_ovf_clear", overflow, 0);
    tick(3);
    bufferError = 1'b1;
    tick(1);
    bufferError = 1'b0;
    check("t4_ovf_set", overflow, 1);
    wait_pkts(4, "t4_done");
    check("t4_ovf_pkt", overflow, 1);
    tick(1);
    check("t4_in_gap", busy, 1);
    check("t4_ovf_gap", overflow, 1);
    wait_idle("t4_idle");
    check("t4_ovf_idle", overflow, 1);
    enable = 1'b0;
    tick(1);
    check("t4_ovf_cleared", overflow, 0);
    bufferError = 1'b1;
    tick(1);
    bufferError = 1'b0;
    check("t4_ovf_gated", overflow, 0);
    check("t4_count", packetCount, 4);

    // reset at word 8
    push_pkt();
    enable = 1'b1; dataAvailable = 1'b1; fx3Ready = 1'b1;
    tick(1);
    dataAvailable = 1'b0; fx3Ready = 1'b0;
    tick(8);
    nReset = 1'b0;
    #1;
    check("t5_rd", readData, 0);
    check("t5_wr", fx3Wr, 0);
    check("t5_end", fx3PktEnd, 0);
    check("t5_busy", busy, 0);
    check("t5_data", fx3Data, 0);
    check("t5_cnt", packetCount, 0);
    pk_before = mon_pkts;
    exp_q.delete();
    tick(2);
    check("t5_no_pkt_end", mon_pkts, pk_before);
    nReset = 1'b1;
    tick(2);
    push_pkt();
    dataAvailable = 1'b1; fx3Ready = 1'b1;
    tick(1);
    dataAvailable = 1'b0; fx3Ready = 1'b0;
    wait_pkts(pk_before + 1, "t5_done");
    wait_idle("t5_idle");
    check("t5_count", packetCount, 1);
    check("sb_empty", exp_q.size(), 0);

    // wait for the wrap instance
    t = 0;
    while (!w_done && t < 700000) begin @(negedge wclk); t++; end
    check("wrap_done", w_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
